frame_mem_arbiter: RTL and testbench

- Shares the single-port 8-bit frame memory (64K x 8) between two requesters: the VGA pixel fetch path and the Sobel filter engine.
- VGA reads are deadline-critical, so they win during active video.
- The Sobel engine gets priority during blanking.
- Sits between the memory macro and both requesters; it returns read data tagged back to the requester that issued each read.

---
 rtl/frame_mem_pkg.sv | 28 ++
 rtl/rd_tag_pipe.sv | 27 ++
 rtl/frame_mem_arbiter.sv | 141 ++++++++++++++
 tb/tb_frame_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_mem_pkg.sv
// Shared types and default widths for the frame memory arbiter and its
// read-tag delay line.
package frame_mem_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  typedef enum logic {
    OWN_VGA = 1'b0,
    OWN_SOB = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    VGA_PRI   = 2'd0,
    SOB_PRI   = 2'd1,
    FORCE_SOB = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  function automatic arb_state_e baseState(input logic videoOn);
    return videoOn ? VGA_PRI : SOB_PRI;
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-length delay line of read tags, aligned so that the last stage
// coincides with the memory returning data for the tagged access.
module rd_tag_pipe
  import frame_mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  tag_t tag_i,
  output tag_t tag_o
);

  tag_t pipe_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/frame_mem_arbiter.sv
// Arbitrates the single-port frame memory between VGA fetch and the Sobel engine.
// Define ARB_STARVE_GUARD_EN to add the Sobel starvation guard (FORCE_SOB).
module frame_mem_arbiter
  import frame_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = 1
`ifdef ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_MAX = 64
`endif
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              video_on_i,
  input  logic              vga_req_i,
  input  logic [ADDR_W-1:0] vga_addr_i,
  output logic              vga_gnt_o,
  output logic              vga_rvalid_o,
  output logic [DATA_W-1:0] vga_rdata_o,
  input  logic              sob_req_i,
  input  logic              sob_we_i,
  input  logic [ADDR_W-1:0] sob_addr_i,
  input  logic [DATA_W-1:0] sob_wdata_i,
  output logic              sob_gnt_o,
  output logic              sob_rvalid_o,
  output logic [DATA_W-1:0] sob_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  arb_state_e        state_q;
  logic              vgaGnt, sobGnt;
  logic              memEn_q, memEn_d;
  logic              memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [DATA_W-1:0] memWdata_q, memWdata_d;
  tag_t              pushTag, tailTag;

  // Grants are suppressed during reset so every output reads 0 there.
  always_comb begin
    vgaGnt = 1'b0;
    sobGnt = 1'b0;
    if (rst_n_i) begin
      unique case (state_q)
        VGA_PRI: begin
          vgaGnt = vga_req_i;
          sobGnt = sob_req_i && !vga_req_i;
        end
        SOB_PRI: begin
          sobGnt = sob_req_i;
          vgaGnt = vga_req_i && !sob_req_i;
        end
        default: sobGnt = sob_req_i;
      endcase
    end
  end

  assign vga_gnt_o = vgaGnt;
  assign sob_gnt_o = sobGnt;

  always_comb begin
    memEn_d    = vgaGnt || sobGnt;
    memWe_d    = sobGnt && sob_we_i;
    memAddr_d  = '0;
    memWdata_d = '0;
    if (sobGnt) memAddr_d = sob_addr_i;
    else if (vgaGnt) memAddr_d = vga_addr_i;
    if (memWe_d) memWdata_d = sob_wdata_i;
    pushTag.valid = vgaGnt || (sobGnt && !sob_we_i);
    pushTag.owner = sobGnt ? OWN_SOB : OWN_VGA;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      memEn_q    <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
    end else begin
      memEn_q    <= memEn_d;
      memWe_q    <= memWe_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
    end
  end

  assign mem_en_o    = memEn_q;
  assign mem_we_o    = memWe_q;
  assign mem_addr_o  = memAddr_q;
  assign mem_wdata_o = memWdata_q;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starveCnt_q;

  // Priority tracks video_on one cycle late; a full run of Sobel denials
  // buys exactly one forced Sobel slot.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= baseState(video_on_i);
      starveCnt_q <= '0;
    end else if (sob_req_i && !sobGnt) begin
      if (starveCnt_q == CNT_W'(STARVE_MAX - 1)) begin
        state_q     <= FORCE_SOB;
        starveCnt_q <= '0;
      end else begin
        state_q     <= baseState(video_on_i);
        starveCnt_q <= starveCnt_q + 1'b1;
      end
    end else begin
      state_q     <= baseState(video_on_i);
      starveCnt_q <= '0;
    end
  end
`else
  // Priority tracks video_on one cycle late, including while in reset.
  always_ff @(posedge clk_i) begin
    state_q <= baseState(video_on_i);
  end
`endif

  rd_tag_pipe #(
    .DEPTH(RD_LAT + 1)
  ) u_rd_tag_pipe (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .tag_i  (pushTag),
    .tag_o  (tailTag)
  );

  assign vga_rvalid_o = tailTag.valid && (tailTag.owner == OWN_VGA);
  assign sob_rvalid_o = tailTag.valid && (tailTag.owner == OWN_SOB);
  assign vga_rdata_o  = vga_rvalid_o ? mem_rdata_i : '0;
  assign sob_rdata_o  = sob_rvalid_o ? mem_rdata_i : '0;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Scoreboard bench for frame_mem_arbiter with a behavioural RD_LAT-cycle memory.
// Also builds with ARB_STARVE_GUARD_EN (STARVE_MAX=4).
module tb_frame_mem_arbiter;

  localparam int RD_LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        video_on;
  logic        vga_req;
  logic [15:0] vga_addr;
  logic        vga_gnt;
  logic        vga_rvalid;
  logic [7:0]  vga_rdata;
  logic        sob_req;
  logic        sob_we;
  logic [15:0] sob_addr;
  logic [7:0]  sob_wdata;
  logic        sob_gnt;
  logic        sob_rvalid;
  logic [7:0]  sob_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  frame_mem_arbiter #(
    .ADDR_W(16),
    .DATA_W(8),
    .RD_LAT(RD_LAT)
`ifdef ARB_STARVE_GUARD_EN
    ,
    .STARVE_MAX(4)
`endif
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .video_on_i  (video_on),
    .vga_req_i   (vga_req),
    .vga_addr_i  (vga_addr),
    .vga_gnt_o   (vga_gnt),
    .vga_rvalid_o(vga_rvalid),
    .vga_rdata_o (vga_rdata),
    .sob_req_i   (sob_req),
    .sob_we_i    (sob_we),
    .sob_addr_i  (sob_addr),
    .sob_wdata_i (sob_wdata),
    .sob_gnt_o   (sob_gnt),
    .sob_rvalid_o(sob_rvalid),
    .sob_rdata_o (sob_rdata),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Unwritten locations hold addr[7:0]^addr[15:8]^0x3C; idle cycles return 0xEE.
  bit [7:0]   memArray [65536];
  bit         wrFlag   [65536];
  logic [7:0] rdPipe   [RD_LAT];

  function automatic logic [7:0] memRead(input logic [15:0] a);
    return wrFlag[a] ? memArray[a] : (a[7:0] ^ a[15:8] ^ 8'h3C);
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      memArray[mem_addr] <= mem_wdata;
      wrFlag[mem_addr]   <= 1'b1;
    end
    rdPipe[0] <= (mem_en && !mem_we) ? memRead(mem_addr) : 8'hEE;
    for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end

  assign mem_rdata = rdPipe[RD_LAT-1];

  typedef struct {
    bit         isSob;
    logic [7:0] data;
    int         cycle;
  } exp_t;

  exp_t scoreQ[$];
  exp_t monE;
  int   testsRun    = 0;
  int   testsFailed = 0;

  logic        expMemEn    = 1'b0;
  logic        expMemWe    = 1'b0;
  logic [15:0] expMemAddr  = '0;
  logic [7:0]  expMemWdata = '0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
               name, cyc, actual, expected);
    end
  endtask

  // Checks last cycle's memory issue, drives this cycle, checks grants and
  // queues the read response the requester should eventually see.
  task automatic applyStimulus(input bit rstN, input bit videoOn,
                               input bit vReq, input logic [15:0] vAddr,
                               input bit sReq, input bit sWe,
                               input logic [15:0] sAddr, input logic [7:0] sWdata,
                               input bit expV, input bit expS,
                               input logic [7:0] expData, input bit pushEn);
    exp_t e;
    @(negedge clk);
    checkOutput("mem_en", 32'(mem_en), 32'(expMemEn));
    checkOutput("mem_we", 32'(mem_we), 32'(expMemWe));
    if (expMemEn) checkOutput("mem_addr", 32'(mem_addr), 32'(expMemAddr));
    if (expMemWe) checkOutput("mem_wdata", 32'(mem_wdata), 32'(expMemWdata));
    rst_n     = rstN;
    video_on  = videoOn;
    vga_req   = vReq;
    vga_addr  = vAddr;
    sob_req   = sReq;
    sob_we    = sWe;
    sob_addr  = sAddr;
    sob_wdata = sWdata;
    #1;
    checkOutput("vga_gnt", 32'(vga_gnt), 32'(expV));
    checkOutput("sob_gnt", 32'(sob_gnt), 32'(expS));
    expMemEn    = expV || expS;
    expMemWe    = expS && sWe;
    expMemAddr  = expS ? sAddr : vAddr;
    expMemWdata = sWdata;
    if (pushEn && (expV || (expS && !sWe))) begin
      e.isSob = expS;
      e.data  = expData;
      e.cycle = cyc + 1 + RD_LAT;
      scoreQ.push_back(e);
    end
  endtask

  function automatic bit forcedAt(input int i);
`ifdef ARB_STARVE_GUARD_EN
    return (i % 5) == 4;
`else
    return (i < 0);
`endif
  endfunction

  always @(negedge clk) begin
    if (scoreQ.size() > 0 && scoreQ[0].cycle < cyc) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL missing_rvalid: no rvalid by cycle %0d, expected at cycle %0d",
               cyc, scoreQ[0].cycle);
      void'(scoreQ.pop_front());
    end
    if (!vga_rvalid) checkOutput("vga_rdata_gated", 32'(vga_rdata), 32'd0);
    if (!sob_rvalid) checkOutput("sob_rdata_gated", 32'(sob_rdata), 32'd0);
    if (vga_rvalid || sob_rvalid) begin
      if (vga_rvalid && sob_rvalid) begin
        checkOutput("rvalid_onehot", 32'({vga_rvalid, sob_rvalid}), 32'd1);
      end else if (scoreQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_rvalid at cycle %0d: got vga=%0b sob=%0b, expected none",
                 cyc, vga_rvalid, sob_rvalid);
      end else begin
        monE = scoreQ.pop_front();
        checkOutput("rvalid_owner", 32'(sob_rvalid), 32'(monE.isSob));
        checkOutput("rvalid_cycle", 32'(cyc), 32'(monE.cycle));
        checkOutput("rdata", 32'(sob_rvalid ? sob_rdata : vga_rdata), 32'(monE.data));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n = 1'b0; video_on = 1'b1;
    vga_req = 1'b1; vga_addr = 16'h1234;
    sob_req = 1'b1; sob_we = 1'b0; sob_addr = 16'h0040; sob_wdata = 8'h00;

    // Reset with both requesters pending: nothing may be granted or issued.
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, 1, 16'h1234, 1, 0, 16'h0040, 8'h00, 0, 0, 8'h00, 0);
    checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("reset_mem_wdata", 32'(mem_wdata), 32'd0);
    checkOutput("reset_vga_rvalid", 32'(vga_rvalid), 32'd0);
    checkOutput("reset_sob_rvalid", 32'(sob_rvalid), 32'd0);

    // Active video contention: VGA wins (0x1234 -> 0x1A); Sobel reads 0x0040 -> 0x7C.
    for (int i = 0; i < 10; i++)
      applyStimulus(1, 1, 1, 16'h1234, 1, 0, 16'h0040, 8'h00,
                    !forcedAt(i), forcedAt(i), forcedAt(i) ? 8'h7C : 8'h1A, 1);

    // Back-to-back interleaved reads: 0x10 -> 0x2C, 0x20 -> 0x1C, 0x30 -> 0x0C.
    applyStimulus(1, 1, 1, 16'h0010, 0, 0, 16'h0000, 8'h00, 1, 0, 8'h2C, 1);
    applyStimulus(1, 1, 0, 16'h0000, 1, 0, 16'h0020, 8'h00, 0, 1, 8'h1C, 1);
    applyStimulus(1, 1, 1, 16'h0030, 0, 0, 16'h0000, 8'h00, 1, 0, 8'h0C, 1);

    // Blanking: first cycle still VGA priority, then Sobel write, read-back, VGA.
    applyStimulus(1, 0, 1, 16'h0010, 1, 1, 16'h00FF, 8'hA5, 1, 0, 8'h2C, 1);
    applyStimulus(1, 0, 1, 16'h0010, 1, 1, 16'h00FF, 8'hA5, 0, 1, 8'h00, 1);
    applyStimulus(1, 0, 1, 16'h0010, 1, 0, 16'h00FF, 8'h00, 0, 1, 8'hA5, 1);
    applyStimulus(1, 0, 1, 16'h0010, 0, 0, 16'h0000, 8'h00, 1, 0, 8'h2C, 1);

    // Back to active video: one lagging Sobel grant, then VGA dominates.
    applyStimulus(1, 1, 1, 16'h1234, 1, 0, 16'h0020, 8'h00, 0, 1, 8'h1C, 1);
    for (int i = 0; i < 8; i++)
      applyStimulus(1, 1, 1, 16'h1234, 1, 0, 16'h0020, 8'h00,
                    !forcedAt(i), forcedAt(i), forcedAt(i) ? 8'h1C : 8'h1A, 1);

    // Idle: no requests, no grants; lets outstanding reads drain.
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 1, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 1);

    // Read accepted, then reset the next cycle: its data must never come back.
    applyStimulus(1, 1, 1, 16'h1234, 0, 0, 16'h0000, 8'h00, 1, 0, 8'h1A, 0);
    applyStimulus(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 0);
    applyStimulus(0, 1, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 0);
    for (int i = 0; i < 6; i++)
      applyStimulus(1, 1, 0, 16'h0000, 0, 0, 16'h0000, 8'h00, 0, 0, 8'h00, 1);

    checkOutput("scoreboard_drained", 32'(scoreQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
